// File: rtl/spi_slave_regfile.sv
// SPI slave (R/W bit, address, data; MSB first) over a register array shared with a host parallel port.
// Optional macro SPI_SLV_AUTOINC_EN: burst transfers with address auto-increment; otherwise one word per frame.
module spi_slave_regfile #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              SCLK,
  input  logic              reset,
  input  logic              CS,
  input  logic              SDI,
  output logic              SDO,
  output logic              busy,
  output logic              frame_err,
  output logic              col_err,
  output logic [7:0]        word_cnt,
  input  logic [ADDR_W-1:0] hst_addr,
  output logic [DATA_W-1:0] hst_rdata,
  input  logic              hst_we,
  input  logic [DATA_W-1:0] hst_wdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RD, S_WR, S_DONE} state_t;

  state_t            state_q;
  logic              rw_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-2:0] tx_sreg_q;
  logic [DATA_W-2:0] rx_sreg_q;
  logic              sdo_q;
  logic              frame_err_q;
  logic              col_err_q;
  logic [7:0]        word_cnt_q;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [ADDR_W-1:0] addr_full_d;
  logic [ADDR_W-1:0] ld_addr_d;
  logic [DATA_W-1:0] ld_word_d;
  logic [DATA_W-1:0] wdata_d;
  logic              last_addr_bit;
  logic              last_data_bit;
  logic              spi_we;
  logic              hst_we_ok;
  logic              col_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  assign addr_full_d   = {addr_q[ADDR_W-2:0], SDI};
  assign wdata_d       = {rx_sreg_q, SDI};
  assign last_addr_bit = (bit_cnt_q == CNT_W'(ADDR_W-1));
  assign last_data_bit = (bit_cnt_q == CNT_W'(DATA_W-1));

`ifdef SPI_SLV_AUTOINC_EN
  logic [ADDR_W-1:0] addr_inc_d;
  assign addr_inc_d = (32'(addr_q) == 32'(DEPTH-1)) ? '0 : addr_q + ADDR_W'(1);
  // In a read burst the next word is fetched on the word-end edge.
  assign ld_addr_d  = (state_q == S_ADDR) ? addr_full_d : addr_inc_d;
`else
  assign ld_addr_d  = addr_full_d;
`endif

  assign ld_word_d = in_range(ld_addr_d) ? mem[ld_addr_d[IDX_W-1:0]] : '0;
  assign hst_rdata = in_range(hst_addr)  ? mem[hst_addr[IDX_W-1:0]]  : '0;

  assign spi_we    = !reset && !CS && (state_q == S_WR) && last_data_bit && in_range(addr_q);
  assign hst_we_ok = !reset && hst_we && in_range(hst_addr);
  assign col_d     = spi_we && hst_we_ok && (hst_addr == addr_q);

  // SPI takes priority over the host on a same-address collision.
  always_ff @(posedge SCLK) begin
    if (spi_we) begin
      mem[addr_q[IDX_W-1:0]] <= wdata_d;
    end
    if (hst_we_ok && !col_d) begin
      mem[hst_addr[IDX_W-1:0]] <= hst_wdata;
    end
  end

  always_ff @(posedge SCLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      tx_sreg_q   <= '0;
      rx_sreg_q   <= '0;
      sdo_q       <= 1'b0;
      frame_err_q <= 1'b0;
      col_err_q   <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      frame_err_q <= 1'b0;
      col_err_q   <= col_d;
      if (CS) begin
        if (state_q != S_IDLE) begin
          frame_err_q <= (word_cnt_q == 8'd0);
        end
        state_q    <= S_IDLE;
        sdo_q      <= 1'b0;
        word_cnt_q <= '0;
        bit_cnt_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            rw_q      <= SDI;
            bit_cnt_q <= '0;
            state_q   <= S_ADDR;
          end
          S_ADDR: begin
            addr_q <= addr_full_d;
            if (last_addr_bit) begin
              bit_cnt_q <= '0;
              if (rw_q) begin
                tx_sreg_q <= ld_word_d[DATA_W-2:0];
                sdo_q     <= ld_word_d[DATA_W-1];
                state_q   <= S_RD;
              end else begin
                state_q <= S_WR;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          S_RD, S_WR: begin
            if (last_data_bit) begin
              bit_cnt_q <= '0;
              if (word_cnt_q != 8'hFF) begin
                word_cnt_q <= word_cnt_q + 8'd1;
              end
`ifdef SPI_SLV_AUTOINC_EN
              addr_q <= addr_inc_d;
              if (state_q == S_RD) begin
                tx_sreg_q <= ld_word_d[DATA_W-2:0];
                sdo_q     <= ld_word_d[DATA_W-1];
              end
`else
              state_q <= S_DONE;
              sdo_q   <= 1'b0;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (state_q == S_RD) begin
                sdo_q     <= tx_sreg_q[DATA_W-2];
                tx_sreg_q <= tx_sreg_q << 1;
              end else begin
                rx_sreg_q <= (DATA_W-1)'({rx_sreg_q, SDI});
              end
            end
          end
          S_DONE: begin
            sdo_q <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign SDO       = sdo_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign col_err   = col_err_q;
  assign word_cnt  = word_cnt_q;

endmodule
